// File: rtl/bit4_fulladder_bh.sv
// 4-bit binary adder with carry in/out: combinational sum and carry, plus a
// one-cycle registered mirror of the result with overflow and zero flags.
module bit4_fulladder_bh (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] s_r,
  output logic       cout_r,
  output logic       ovf_r,
  output logic       zero_r
);

  logic [4:0] sum_full;
  logic       ovf;

  // Widen every operand to 5 bits so the carry is never lost before it is taken.
  assign sum_full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign s        = sum_full[3:0];
  assign cout     = sum_full[4];
  assign ovf      = (a[3] & b[3] & ~s[3]) | (~a[3] & ~b[3] & s[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r    <= 4'd0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b1;
    end else begin
      s_r    <= s;
      cout_r <= cout;
      ovf_r  <= ovf;
      // The zero flag looks only at the 4-bit sum; a carry-out does not clear it.
      zero_r <= (s == 4'd0);
    end
  end

endmodule

// File: tb/tb_bit4_fulladder_bh.sv
// Self-checking bench for bit4_fulladder_bh: vector table, exhaustive sweep,
// scoreboard for the registered path, reset and no-clock sequences.
module tb_bit4_fulladder_bh;

  typedef struct {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } reg_exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic [3:0] a, b, s, s_r;
  logic       cin, clk, rst, cout, cout_r, ovf_r, zero_r;
  logic       clk_en;

  int total = 0;
  int bad   = 0;

  reg_exp_t sb_q[$];
  reg_exp_t last_pushed;
  reg_exp_t prev_pushed;
  reg_exp_t rst_exp;

  bit4_fulladder_bh dut (
    .s      (s),
    .cout   (cout),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .clk    (clk),
    .rst    (rst),
    .s_r    (s_r),
    .cout_r (cout_r),
    .ovf_r  (ovf_r),
    .zero_r (zero_r)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs on the falling edge and queue what the registers must show
  // after the next rising edge.
  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic tr, input reg_exp_t e);
    @(negedge clk);
    a = ta; b = tb; cin = tc; rst = tr;
    prev_pushed = last_pushed;
    last_pushed = e;
    sb_q.push_back(e);
  endtask

  // Scoreboard: compare registered outputs just after each rising edge.
  always @(posedge clk) begin
    reg_exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("s_r",    {4'h0, s_r},    {4'h0, e.s});
      check("cout_r", {7'h0, cout_r}, {7'h0, e.cout});
      check("ovf_r",  {7'h0, ovf_r},  {7'h0, e.ovf});
      check("zero_r", {7'h0, zero_r}, {7'h0, e.zero});
    end
  end

  initial begin
    vec_t vecs[8];
    reg_exp_t e;
    logic [4:0] full;
    logic [3:0] hs;
    logic [3:0] hold_s;
    logic hold_c, hold_o, hold_z;

    vecs[0] = '{a:4'd15, b:4'd15, cin:1'b1, s:4'd15, cout:1'b1, ovf:1'b0, zero:1'b0};
    vecs[1] = '{a:4'd15, b:4'd0,  cin:1'b1, s:4'd0,  cout:1'b1, ovf:1'b0, zero:1'b1};
    vecs[2] = '{a:4'd7,  b:4'd1,  cin:1'b0, s:4'd8,  cout:1'b0, ovf:1'b1, zero:1'b0};
    vecs[3] = '{a:4'd8,  b:4'd8,  cin:1'b0, s:4'd0,  cout:1'b1, ovf:1'b1, zero:1'b1};
    vecs[4] = '{a:4'd0,  b:4'd0,  cin:1'b0, s:4'd0,  cout:1'b0, ovf:1'b0, zero:1'b1};
    vecs[5] = '{a:4'd5,  b:4'd2,  cin:1'b0, s:4'd7,  cout:1'b0, ovf:1'b0, zero:1'b0};
    vecs[6] = '{a:4'd9,  b:4'd9,  cin:1'b1, s:4'd3,  cout:1'b1, ovf:1'b1, zero:1'b0};
    vecs[7] = '{a:4'd6,  b:4'd9,  cin:1'b0, s:4'd15, cout:1'b0, ovf:1'b0, zero:1'b0};

    rst_exp = '{s:4'd0, cout:1'b0, ovf:1'b0, zero:1'b1};
    last_pushed = rst_exp;
    prev_pushed = rst_exp;

    a = 4'd0; b = 4'd0; cin = 1'b0; rst = 1'b1; clk_en = 1'b1;

    // Reset held over two edges: registers at reset values.
    drive(4'd5, 4'd6, 1'b0, 1'b1, rst_exp);
    drive(4'd5, 4'd6, 1'b0, 1'b1, rst_exp);
    $display("reset held two cycles");

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      e = '{s:vecs[i].s, cout:vecs[i].cout, ovf:vecs[i].ovf, zero:vecs[i].zero};
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, e);
      #1;
      check("vec_s",    {4'h0, s},    {4'h0, vecs[i].s});
      check("vec_cout", {7'h0, cout}, {7'h0, vecs[i].cout});
      $display("vec %0d: a=%0d b=%0d cin=%0d -> s=%0d cout=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].cin, s, cout);
    end

    // Exhaustive sweep, one combination per 10 ns clock period.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ta, tb;
      logic tc;
      ta = i[8:5]; tb = i[4:1]; tc = i[0];
      full = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
      hs = full[3:0];
      e = '{s:hs, cout:full[4],
            ovf:(ta[3] & tb[3] & ~hs[3]) | (~ta[3] & ~tb[3] & hs[3]),
            zero:(hs == 4'd0)};
      drive(ta, tb, tc, 1'b0, e);
      #1;
      check("sweep_sum", {3'h0, cout, s}, {3'h0, full});
    end
    $display("sweep of 512 combinations done");

    // Latency: before the edge the previous registered value is still visible.
    drive(4'd0, 4'd0, 1'b0, 1'b0, rst_exp);
    drive(4'd3, 4'd4, 1'b1, 1'b0, '{s:4'd8, cout:1'b0, ovf:1'b1, zero:1'b0});
    #1;
    check("lat_s_now",   {4'h0, s},   8'd8);
    check("lat_s_r_old", {4'h0, s_r}, {4'h0, prev_pushed.s});
    $display("latency: a=3 b=4 cin=1 s=%0d s_r before edge=%0d", s, s_r);

    // Reset raised between edges: s_r holds 8 until the next edge.
    drive(4'd3, 4'd4, 1'b1, 1'b1, rst_exp);
    #1;
    check("rst_hold_s_r", {4'h0, s_r}, 8'd8);
    check("rst_s_live",   {4'h0, s},   8'd8);
    @(posedge clk); #2;
    check("rst_s_after",  {4'h0, s},   8'd8);
    drive(4'd3, 4'd4, 1'b1, 1'b1, rst_exp);
    drive(4'd3, 4'd4, 1'b1, 1'b0, '{s:4'd8, cout:1'b0, ovf:1'b1, zero:1'b0});
    $display("sync reset mid-operation, then release");

    // Stop the clock and toggle inputs: registers must not move.
    @(posedge clk); #2;
    check("sb_empty", {7'h0, sb_q.size() == 0}, 8'd1);
    @(negedge clk);
    clk_en = 1'b0;
    rst = 1'b0;
    hold_s = s_r; hold_c = cout_r; hold_o = ovf_r; hold_z = zero_r;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ta, tb;
      logic tc;
      ta = 4'($urandom_range(0, 15));
      tb = 4'($urandom_range(0, 15));
      tc = 1'($urandom_range(0, 1));
      a = ta; b = tb; cin = tc;
      #10;
      full = {1'b0, ta} + {1'b0, tb} + {4'd0, tc};
      check("noclk_sum", {3'h0, cout, s}, {3'h0, full});
      check("noclk_regs", {1'h0, s_r, cout_r, ovf_r, zero_r},
            {1'h0, hold_s, hold_c, hold_o, hold_z});
      $display("no-clock: a=%0d b=%0d cin=%0d -> s=%0d cout=%0d", ta, tb, tc, s, cout);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
